scan_mux_4digit: RTL and testbench

SCAN_MUX_4DIGIT -- requirements
Module: scan_mux_4digit

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_tick.sv | 26 ++
 rtl/scan_mux_4digit.sv | 129 ++++++++++++
 tb/tb_scan_mux_4digit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the 4-digit scan multiplexer.
package scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;

  typedef enum logic [1:0] {
    SCAN0,
    SCAN1,
    SCAN2,
    SCAN3
  } scan_state_e;

endpackage

// File: rtl/scan_tick.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1, tick on the last count.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/scan_mux_4digit.sv
// Four-digit hex display scanner with tear-free shadow/display buffering.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module scan_mux_4digit
  import scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter logic [15:0] DISP_RESET = 16'h0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] value,
  input  logic                           load,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  output logic [NIBBLE_W-1:0]            nibble,
  output logic                           dp,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic                           blank,
  output logic                           frame_done
);

  logic tick;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  scan_state_e state_q, state_d;
  logic        frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SCAN0:   state_d = SCAN1;
        SCAN1:   state_d = SCAN2;
        SCAN2:   state_d = SCAN3;
        SCAN3:   state_d = SCAN0;
        default: state_d = SCAN0;
      endcase
    end
  end

  assign frame_end = tick && (state_q == SCAN3);

  logic [15:0]           shadow_q, display_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q, display_dp_q;
  logic                  pending_q;

  // Display only moves on the frame boundary so a frame never shows mixed data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= DISP_RESET;
      shadow_dp_q  <= '0;
      display_q    <= DISP_RESET;
      display_dp_q <= '0;
      pending_q    <= 1'b0;
    end else if (frame_end) begin
      pending_q <= 1'b0;
      if (load) begin
        display_q    <= value;
        display_dp_q <= dp_in;
      end else if (pending_q) begin
        display_q    <= shadow_q;
        display_dp_q <= shadow_dp_q;
      end
    end else if (load) begin
      shadow_q    <= value;
      shadow_dp_q <= dp_in;
      pending_q   <= 1'b1;
    end
  end

  logic [1:0]            idx;
  logic [NIBBLE_W-1:0]   nibble_d;
  logic                  dp_d, blank_d;
  logic [NUM_DIGITS-1:0] digit_sel_d;

  assign idx = 2'(state_q);

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  assign upper = display_q >> {idx, 2'b00};
`endif

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_d = (state_q != SCAN0) && (upper == 16'h0000);
`else
    blank_d = 1'b0;
`endif
    nibble_d    = display_q[{idx, 2'b00} +: NIBBLE_W];
    dp_d        = display_dp_q[idx];
    digit_sel_d = 4'b0001 << idx;
    if (blank_d) begin
      nibble_d    = '0;
      dp_d        = 1'b0;
      digit_sel_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble     <= DISP_RESET[3:0];
      dp         <= 1'b0;
      digit_sel  <= 4'b0001;
      blank      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      nibble     <= nibble_d;
      dp         <= dp_d;
      digit_sel  <= digit_sel_d;
      blank      <= blank_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_scan_mux_4digit.sv
// Scoreboard bench for scan_mux_4digit with a cycle-count reference model.
module tb_scan_mux_4digit;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  nibble;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        blank;
  logic        frame_done;

  scan_mux_4digit #(
    .SCAN_DIV  (SD),
    .DISP_RESET(16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .dp_in     (dp_in),
    .nibble    (nibble),
    .dp        (dp),
    .digit_sel (digit_sel),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic [3:0] sel;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference state: cycles since reset release, displayed value, pending shadow.
  int          m_cyc = 0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_ddp = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_shv = '0;
  logic [3:0]  m_shdp = '0;

  function automatic exp_t expect_for(int slot, logic [15:0] d, logic [3:0] ddp, logic fd);
    exp_t        e;
    logic [15:0] up;
    up      = d >> (4 * slot);
    e.blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && up == 16'h0000) e.blank = 1'b1;
`endif
    e.fd = fd;
    if (e.blank) begin
      e.nib = 4'h0;
      e.dp  = 1'b0;
      e.sel = 4'b0000;
    end else begin
      e.nib = up[3:0];
      e.dp  = ddp[slot];
      e.sel = 4'(1 << slot);
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_cyc  = 0;
        m_disp = 16'h0000;
        m_ddp  = '0;
        m_pend = 1'b0;
        m_shv  = 16'h0000;
        m_shdp = '0;
        q.push_back(expect_for(0, 16'h0000, 4'b0000, 1'b0));
      end else begin
        int   slot;
        logic bnd;
        slot = (m_cyc / SD) % 4;
        bnd  = (m_cyc % FRAME) == FRAME - 1;
        q.push_back(expect_for(slot, m_disp, m_ddp, bnd));
        if (bnd) begin
          if (load) begin
            m_disp = value;
            m_ddp  = dp_in;
          end else if (m_pend) begin
            m_disp = m_shv;
            m_ddp  = m_shdp;
          end
          m_pend = 1'b0;
        end else if (load) begin
          m_shv  = value;
          m_shdp = dp_in;
          m_pend = 1'b1;
        end
        m_cyc++;
      end
    end
  end

  // Monitor: one registered output set per cycle, sampled on the falling edge.
  int out_idx = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e, g;
        e = q.pop_front();
        g = '{nib: nibble, dp: dp, sel: digit_sel, blank: blank, fd: frame_done};
        n_checks++;
        if (g === e) begin
          n_pass++;
        end else begin
          $display("FAIL out%0d: got nib=%h dp=%b sel=%b blank=%b fd=%b, want nib=%h dp=%b sel=%b blank=%b fd=%b",
                   out_idx, g.nib, g.dp, g.sel, g.blank, g.fd, e.nib, e.dp, e.sel, e.blank, e.fd);
        end
        out_idx++;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    tick_n(1);
    load  = 1'b0;
    value = 16'($urandom);
    dp_in = 4'($urandom);
  endtask

  task automatic align(input int k);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != k; i++) tick_n(1);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick_n(2);
    load  = 1'b1;
    value = 16'hBEEF;
    dp_in = 4'b1111;
    tick_n(1);
    load  = 1'b0;
    tick_n(1);
    rst = 1'b0;
    tick_n(40);

    align(5);
    do_load(16'h1A2F, 4'b0100);
    tick_n(40);

    align(15);
    do_load(16'h3C07, 4'b1001);
    tick_n(20);

    align(2);
    do_load(16'h1111, 4'b0000);
    tick_n(3);
    do_load(16'h2222, 4'b0010);
    tick_n(40);

    do_load(16'h0050, 4'b1000);
    tick_n(40);
    do_load(16'h0000, 4'b0110);
    tick_n(40);

    do_load(16'h9876, 4'b0001);
    tick_n(20);
    align(9);
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    tick_n(24);

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        do_load(16'($urandom) >> $urandom_range(0, 16), 4'($urandom));
      end else begin
        tick_n(1);
      end
    end

    tick_n(3);
    n_checks++;
    if (q.size() <= 1) n_pass++;
    else $display("FAIL queue_drain: got %0d pending, want at most 1", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
